// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline register with a valid/ready handshake backed by a 2-entry skid buffer.
// Freeze holds everything, flush empties the stage and bumps a saturating debug counter.
module if_id_skid_stage #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               freeze,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic               m_valid_q, m_valid_d;
  logic [PC_W-1:0]    m_pc_q,    m_pc_d;
  logic [INSTR_W-1:0] m_instr_q, m_instr_d;
  logic               s_valid_q, s_valid_d;
  logic [PC_W-1:0]    s_pc_q,    s_pc_d;
  logic [INSTR_W-1:0] s_instr_q, s_instr_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic in_xfer;
  logic out_xfer;
  logic drain;

  assign in_ready  = ~s_valid_q & ~freeze;
  assign out_valid = m_valid_q & ~freeze;
  assign occupancy = 2'(m_valid_q) + 2'(s_valid_q);
  assign out_pc    = m_pc_q;
  assign out_instr = m_instr_q;
  assign flush_cnt = flush_cnt_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  // Main can take a new beat when it is leaving this cycle or already empty.
  assign drain    = out_xfer | ~m_valid_q;

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path infers a latch.
    m_valid_d   = m_valid_q;
    m_pc_d      = m_pc_q;
    m_instr_d   = m_instr_q;
    s_valid_d   = s_valid_q;
    s_pc_d      = s_pc_q;
    s_instr_d   = s_instr_q;
    flush_cnt_d = flush_cnt_q;

    if (freeze) begin
      // Hold everything; a pending flush waits for freeze to drop.
    end else if (flush) begin
      m_valid_d = 1'b0;
      m_pc_d    = '0;
      m_instr_d = '0;
      s_valid_d = 1'b0;
      s_pc_d    = '0;
      s_instr_d = '0;
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (drain) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_pc_d    = s_pc_q;
        m_instr_d = s_instr_q;
        s_valid_d = 1'b0;
      end else if (in_xfer) begin
        m_valid_d = 1'b1;
        m_pc_d    = in_pc;
        m_instr_d = in_instr;
      end else begin
        m_valid_d = 1'b0;
        m_pc_d    = '0;
        m_instr_d = '0;
      end
    end else if (in_xfer) begin
      s_valid_d = 1'b1;
      s_pc_d    = in_pc;
      s_instr_d = in_instr;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      m_valid_q   <= 1'b0;
      m_pc_q      <= '0;
      m_instr_q   <= '0;
      s_valid_q   <= 1'b0;
      s_pc_q      <= '0;
      s_instr_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_pc_q      <= m_pc_d;
      m_instr_q   <= m_instr_d;
      s_valid_q   <= s_valid_d;
      s_pc_q      <= s_pc_d;
      s_instr_q   <= s_instr_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Self-checking bench for if_id_skid_stage: directed scenarios plus a randomized run
// compared against a FIFO-queue reference model of the stage.
module tb_if_id_skid_stage;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 16;
  localparam int VW      = 2 + 2 + PC_W + INSTR_W + CNT_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, freeze, flush, in_valid, in_ready, out_valid, out_ready;
  logic [PC_W-1:0]    in_pc, out_pc;
  logic [INSTR_W-1:0] in_instr, out_instr;
  logic [1:0]         occupancy;
  logic [CNT_W-1:0]   flush_cnt;

  // Second instance with a 2-bit counter for the saturation scenario.
  logic               sat_reset, sat_flush, sat_in_ready, sat_out_valid;
  logic [PC_W-1:0]    sat_out_pc;
  logic [INSTR_W-1:0] sat_out_instr;
  logic [1:0]         sat_occupancy;
  logic [1:0]         sat_flush_cnt;

  if_id_skid_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .occupancy(occupancy), .flush_cnt(flush_cnt)
  );

  if_id_skid_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(2)) u_dut_sat (
    .clk(clk), .reset(sat_reset), .freeze(1'b0), .flush(sat_flush),
    .in_valid(1'b0), .in_ready(sat_in_ready), .in_pc('0), .in_instr('0),
    .out_valid(sat_out_valid), .out_ready(1'b1), .out_pc(sat_out_pc), .out_instr(sat_out_instr),
    .occupancy(sat_occupancy), .flush_cnt(sat_flush_cnt)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: the stage is a FIFO of at most two beats.
  logic [PC_W-1:0]    mq_pc[$];
  logic [INSTR_W-1:0] mq_ins[$];
  int                 m_cnt = 0;

  function automatic logic [VW-1:0] obs_vec();
    return {in_ready, out_valid, occupancy, out_pc, out_instr, flush_cnt};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    int n = mq_pc.size();
    logic [PC_W-1:0]    p   = '0;
    logic [INSTR_W-1:0] ins = '0;
    if (n > 0) begin
      p   = mq_pc[0];
      ins = mq_ins[0];
    end
    return {1'((n < 2) && !freeze), 1'((n > 0) && !freeze), 2'(n), p, ins, CNT_W'(m_cnt)};
  endfunction

  task automatic tick();
    bit ix, ox;
    @(posedge clk);
    if (!reset) begin
      mq_pc.delete(); mq_ins.delete(); m_cnt = 0;
    end else if (freeze) begin
    end else if (flush) begin
      mq_pc.delete(); mq_ins.delete();
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end else begin
      ix = in_valid && (mq_pc.size() < 2);
      ox = out_ready && (mq_pc.size() > 0);
      if (ox) begin
        void'(mq_pc.pop_front()); void'(mq_ins.pop_front());
      end
      if (ix) begin
        mq_pc.push_back(in_pc); mq_ins.push_back(in_instr);
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic rst_v, input logic frz, input logic fl, input logic iv,
                       input logic [PC_W-1:0] pc, input logic ordy);
    reset     = rst_v;
    freeze    = frz;
    flush     = fl;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = $urandom;
    out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
    tick();
    tick();
    tests_run++;
    if (obs_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL reset_state: got %h expected %h", obs_vec(), exp_vec());
    end
    tests_run++;
    if ({out_valid, occupancy, out_pc, out_instr, flush_cnt} !== '0) begin
      tests_failed++;
      $display("FAIL reset_zero: got v=%b occ=%0d pc=%h ins=%h cnt=%0d expected all zero",
               out_valid, occupancy, out_pc, out_instr, flush_cnt);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, PC_W'(4 * i), 1'b1);
      tick();
      tests_run++;
      if (obs_vec() !== exp_vec() || out_pc !== PC_W'(4 * i) || occupancy !== 2'd1
          || out_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream_%0d: got %h expected %h (pc want %h)", i, obs_vec(), exp_vec(), 4 * i);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [PC_W-1:0] want[3] = '{32'h10, 32'h14, 32'h18};
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h14, 1'b0);
    tick();
    tests_run++;
    if (obs_vec() !== exp_vec() || occupancy !== 2'd2 || in_ready !== 1'b0 || out_pc !== 32'h10) begin
      tests_failed++;
      $display("FAIL bp_skid_fill: got %h expected %h", obs_vec(), exp_vec());
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h18, 1'b0);
    tick();
    tests_run++;
    if (obs_vec() !== exp_vec() || occupancy !== 2'd2 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_hold_upstream: got %h expected %h", obs_vec(), exp_vec());
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h18, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (obs_vec() !== exp_vec() || out_valid !== 1'b1 || out_pc !== want[k]) begin
        tests_failed++;
        $display("FAIL bp_drain_%0d: got pc=%h v=%b expected pc=%h v=1", k, out_pc, out_valid, want[k]);
      end
      tick();
      if (k == 1) drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_flush_full();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h30, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h34, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 1'b0);
    tests_run++;
    if (occupancy !== 2'd2) begin
      tests_failed++;
      $display("FAIL flush_prefill: got occ=%0d expected 2", occupancy);
    end
    tick();
    tests_run++;
    if (obs_vec() !== exp_vec() || occupancy !== 2'd0 || out_valid !== 1'b0
        || out_instr !== '0 || flush_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL flush_full: got %h expected %h", obs_vec(), exp_vec());
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b0 || out_pc === 32'h20) begin
        tests_failed++;
        $display("FAIL flush_discard_%0d: got v=%b pc=%h expected v=0", k, out_valid, out_pc);
      end
    end
  endtask

  task automatic test_freeze_priority();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h44, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h48, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++;
      if (obs_vec() !== exp_vec() || in_ready !== 1'b0 || out_valid !== 1'b0
          || occupancy !== 2'd2 || out_pc !== 32'h40 || flush_cnt !== 16'd1) begin
        tests_failed++;
        $display("FAIL freeze_hold_%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h48, 1'b1);
    tick();
    tests_run++;
    if (obs_vec() !== exp_vec() || occupancy !== 2'd0 || flush_cnt !== 16'd2) begin
      tests_failed++;
      $display("FAIL freeze_release_flush: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0), PC_W'($urandom), ($urandom_range(0, 2) != 0));
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL random_%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    int want;
    sat_reset = 1'b0;
    sat_flush = 1'b0;
    tick();
    sat_reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sat_flush = 1'b1;
      tick();
      want = (k + 1 > 3) ? 3 : k + 1;
      tests_run++;
      if (sat_flush_cnt !== 2'(want)) begin
        tests_failed++;
        $display("FAIL sat_cnt_%0d: got %0d expected %0d", k, sat_flush_cnt, want);
      end
      sat_flush = 1'b0;
      tick();
    end
  endtask

  initial begin
    sat_reset = 1'b0;
    sat_flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_freeze_priority();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/if_id_skid_stage.md
Name: if_id_skid_stage

Overview:
- Next-generation IF/ID pipeline register: parametrised PC and instruction widths.
- Replaces bare freeze/flush with a valid/ready handshake backed by a 2-entry skid buffer, so fetch runs at full throughput under decode backpressure.
- Keeps the freeze and flush controls from the previous generation.
- Adds occupancy and a saturating flush-event counter for hazard-unit debug.
- Sits between the instruction-fetch stage and the decode stage.

Parameters:
- PC_W, 32, width of the program counter field.
- INSTR_W, 32, width of the instruction field.
- CNT_W, 16, width of the flush-event counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- freeze  input  1  stall from the hazard unit; holds all state.
- flush  input  1  squash from branch resolution; empties the stage.
- in_valid  input  1  fetch presents a beat.
- in_ready  output  1  stage can accept a beat.
- in_pc  input  PC_W  PC of the incoming instruction.
- in_instr  input  INSTR_W  incoming instruction word.
- out_valid  output  1  stage presents a beat to decode.
- out_ready  input  1  decode accepts the beat.
- out_pc  output  PC_W  registered PC.
- out_instr  output  INSTR_W  registered instruction.
- occupancy  output  2  number of valid entries (0..2).
- flush_cnt  output  CNT_W  count of effective flush events.

Behaviour:
- State: main entry (m_valid, m_pc, m_instr) drives the outputs; skid entry (s_valid, s_pc, s_instr).
- Reset (reset==0 at a clock edge):
  - Clears both valids, all payload registers and flush_cnt to 0.
  - Outputs after reset: out_valid=0, out_pc=0, out_instr=0, occupancy=0, flush_cnt=0, in_ready=1.
  - Reset overrides freeze and flush.
  - Asserting reset mid-stream discards all held beats.
- Combinational outputs:
  - in_ready = ~s_valid & ~freeze.
  - out_valid = m_valid & ~freeze.
  - occupancy = m_valid + s_valid.
- Transfer definitions: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
- Priority per edge: reset > freeze > flush > normal.
- Freeze:
  - No register changes, including flush_cnt.
  - A flush asserted while frozen is ignored; the hazard unit must hold flush until freeze drops. This matches the previous generation's freeze-over-flush ordering.
- Flush (not frozen):
  - m_valid=0, s_valid=0, and all payloads are zeroed so decode sees a NOP with PC 0.
  - A beat accepted in the same cycle (in_xfer) is discarded.
  - flush_cnt increments by 1 and saturates at all-ones.
- Normal operation (let drain = out_xfer | ~m_valid):
  - drain & s_valid: main <= skid; s_valid <= 0. in_xfer is necessarily 0 in this case.
  - drain & ~s_valid & in_xfer: main <= input.
  - drain & ~s_valid & ~in_xfer: m_valid <= 0; main payload zeroed.
  - ~drain & in_xfer: skid <= input; s_valid <= 1. Main holds.
  - ~drain & ~in_xfer: hold.
- Latency: 1 cycle from in_xfer into an empty stage to out_valid.
- Throughput: 1 beat/cycle sustained when out_ready stays high.
- Ordering: beats leave in strict acceptance order; the skid entry is always younger than main.
- Full: occupancy==2 gives in_ready=0. The first out_xfer moves skid to main, and in_ready rises on the next cycle.
- Backpressure: when out_ready drops, at most one extra beat is absorbed into skid. No beat is ever lost or duplicated except by flush or reset.
- Payload of main and skid is X-free: it is either loaded data or zero.

Test Plan:
- Reset/idle: hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0, out_pc=0, out_instr=0, occupancy=0, flush_cnt=0; in_ready=1 after release.
- Streaming: out_ready=1; send PCs 0x0,0x4,0x8,0xC, one per cycle -> each appears on out_pc exactly 1 cycle later, in order, out_valid continuous, occupancy=1.
- Backpressure/skid:
  - Drop out_ready while PC 0x10 is in main and 0x14 is offered -> 0x14 is accepted into skid, occupancy=2, in_ready=0, 0x18 is held upstream.
  - Raise out_ready -> outputs 0x10, 0x14, 0x18 in consecutive cycles.
- Flush with full stage: occupancy=2, assert flush for 1 cycle while in_valid=1 with PC 0x20 -> next cycle occupancy=0, out_valid=0, out_instr=0, flush_cnt=1, and 0x20 is never output.
- Freeze priority:
  - Set freeze=1 together with flush=1 for 3 cycles -> state unchanged, in_ready=0, out_valid=0, flush_cnt unchanged.
  - Release freeze with flush still high -> stage empties, flush_cnt increments.
- Counter saturation: CNT_W=2, apply 5 single-cycle flushes -> flush_cnt reads 1,2,3,3,3.
